// File: rtl/subcycle_sequencer.sv
// Two-phase clock generator and 8-subcycle instruction-cycle sequencer for the i4004 core.
// Optional halt/single-step control is enabled by defining SUBCYCLE_SEQUENCER_SINGLE_STEP_EN.
module subcycle_sequencer #(
  parameter int PHI1_W  = 20,
  parameter int GAP12_W = 10,
  parameter int PHI2_W  = 20,
  parameter int GAP21_W = 18
) (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       poc_pad,
  input  logic       test_pad,
  input  logic       io_write,
  output logic       clk1,
  output logic       clk2,
  output logic       a12,
  output logic       a22,
  output logic       a32,
  output logic       m12,
  output logic       m22,
  output logic       x12,
  output logic       x22,
  output logic       x32,
  output logic       sync,
  output logic       poc,
  output logic       data_oe,
  output logic       test_q,
  output logic [2:0] subcycle
`ifdef SUBCYCLE_SEQUENCER_SINGLE_STEP_EN
  ,
  input  logic       halt,
  input  logic       step
`endif
);

  localparam int T  = PHI1_W + GAP12_W + PHI2_W + GAP21_W;
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST    = cnt_t'(T - 1);
  localparam cnt_t CLK1_HI = cnt_t'(PHI1_W);
  localparam cnt_t CLK2_LO = cnt_t'(PHI1_W + GAP12_W);
  localparam cnt_t CLK2_HI = cnt_t'(PHI1_W + GAP12_W + PHI2_W);

  if (PHI1_W < 1 || GAP12_W < 1 || PHI2_W < 1 || GAP21_W < 1) begin : g_cfg_err
    $error("subcycle_sequencer: every phase width must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t     state, state_nxt;
  cnt_t       cnt, cnt_nxt;
  logic [2:0] sub_nxt;
  logic       adv;
  logic [7:0] strb;
  logic [1:0] poc_s, test_s;
  logic       io_lat, io_lat_nxt, poc_nxt;
  logic       hold_req, resume;

  assign {x32, x22, x12, m22, m12, a32, a22, a12} = strb;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      poc_s  <= '0;
      test_s <= '0;
    end else begin
      poc_s  <= {poc_s[0], poc_pad};
      test_s <= {test_s[0], test_pad};
    end
  end

`ifdef SUBCYCLE_SEQUENCER_SINGLE_STEP_EN
  logic [2:0] step_s;
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) step_s <= '0;
    else        step_s <= {step_s[1:0], step};
  end
  assign hold_req = halt;
  // A new clear request must never be stuck behind a halted sequencer.
  assign resume   = !halt || (step_s[1] && !step_s[2]) || (poc_s[1] && !poc);
`else
  assign hold_req = 1'b0;
  assign resume   = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sub_nxt   = subcycle;
    adv       = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
        sub_nxt   = 3'd0;
      end
      S_RUN: begin
        if (cnt == LAST) begin
          if (subcycle == 3'd7 && hold_req) begin
            state_nxt = S_HALT;
          end else begin
            cnt_nxt = '0;
            sub_nxt = subcycle + 3'd1;
            adv     = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + cnt_t'(1);
        end
      end
      S_HALT: begin
        if (resume) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          sub_nxt   = 3'd0;
          adv       = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      subcycle <= 3'd7;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      subcycle <= sub_nxt;
    end
  end

  // Release of clear is aligned to the X3->A1 boundary so the core starts a clean cycle.
  always_comb begin
    poc_nxt = poc;
    if (poc_s[1])                       poc_nxt = 1'b1;
    else if (adv && subcycle == 3'd7)   poc_nxt = 1'b0;
    io_lat_nxt = (adv && subcycle == 3'd5) ? io_write : io_lat;
  end

  // Outputs are registered from next-state values so they move on the same edge as the counter.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      clk1    <= 1'b0;
      clk2    <= 1'b0;
      strb    <= '0;
      sync    <= 1'b0;
      poc     <= 1'b1;
      io_lat  <= 1'b0;
      data_oe <= 1'b0;
      test_q  <= 1'b0;
    end else begin
      clk1    <= (cnt_nxt < CLK1_HI);
      clk2    <= (cnt_nxt >= CLK2_LO) && (cnt_nxt < CLK2_HI);
      strb    <= 8'b1 << sub_nxt;
      sync    <= (sub_nxt == 3'd7);
      poc     <= poc_nxt;
      io_lat  <= io_lat_nxt;
      data_oe <= !poc_nxt && ((sub_nxt <= 3'd2) || (sub_nxt >= 3'd6 && io_lat_nxt));
      if (adv && subcycle == 3'd7) test_q <= test_s[1];
    end
  end

endmodule

// File: tb/tb_subcycle_sequencer.sv
// Directed self-checking bench for subcycle_sequencer (default parameters, 20 ns sysclk).
module tb_subcycle_sequencer;
  logic sysclk = 1'b0, poc_n = 1'b0, poc_pad = 1'b1, test_pad = 1'b0, io_write = 1'b1;
  logic clk1, clk2, a12, a22, a32, m12, m22, x12, x22, x32, sync, poc, data_oe, test_q;
  logic [2:0] subcycle;
`ifdef SUBCYCLE_SEQUENCER_SINGLE_STEP_EN
  logic halt = 1'b0, step = 1'b0;
`endif
  int tests = 0, fails = 0;

  always #10 sysclk = ~sysclk;

  subcycle_sequencer dut (
    .sysclk(sysclk), .poc_n(poc_n), .poc_pad(poc_pad), .test_pad(test_pad),
    .io_write(io_write), .clk1(clk1), .clk2(clk2),
    .a12(a12), .a22(a22), .a32(a32), .m12(m12), .m22(m22),
    .x12(x12), .x22(x22), .x32(x32), .sync(sync), .poc(poc),
    .data_oe(data_oe), .test_q(test_q), .subcycle(subcycle)
`ifdef SUBCYCLE_SEQUENCER_SINGLE_STEP_EN
    , .halt(halt), .step(step)
`endif
  );

  wire [7:0] strb = {x32, x22, x12, m22, m12, a32, a22, a12};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_clk"}, 32'({clk1, clk2}), 32'd0);
    chk({tag, "_strb"}, 32'(strb), 32'd0);
    chk({tag, "_sync"}, 32'(sync), 32'd0);
    chk({tag, "_poc"}, 32'(poc), 32'd1);
    chk({tag, "_oe"}, 32'(data_oe), 32'd0);
    chk({tag, "_testq"}, 32'(test_q), 32'd0);
    chk({tag, "_sub"}, 32'(subcycle), 32'd7);
  endtask

  // n = rising edges since the start edge (start edge is n = 0)
  task automatic chk_run(input int n, input logic pe, input logic de, input logic tq);
    int c, s;
    c = n % 68;
    s = (n / 68) % 8;
    chk("clk1", 32'(clk1), 32'(c < 20));
    chk("clk2", 32'(clk2), 32'(c >= 30 && c < 50));
    chk("strb", 32'(strb), 32'(1) << s);
    chk("sync", 32'(sync), 32'(s == 7));
    chk("sub", 32'(subcycle), 32'(s));
    chk("poc", 32'(poc), 32'(pe));
    chk("oe", 32'(data_oe), 32'(de));
    chk("testq", 32'(test_q), 32'(tq));
  endtask

  task automatic chk_frozen();
    chk("h_clk", 32'({clk1, clk2}), 32'd0);
    chk("h_strb", 32'(strb), 32'h80);
    chk("h_sub", 32'(subcycle), 32'd7);
  endtask

  initial begin
    logic pe, iow, de, tq;
    int s;
    #95;
    chk_reset("rst");
    #5 poc_n = 1'b1;  // t = 100 ns
    for (int n = 0; n <= 2550; n++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      s   = (n / 68) % 8;
      pe  = (n < 544) || (n >= 1735);
      iow = (n >= 952 && n < 1496) || (n >= 2040);
      de  = !pe && (s <= 2 || (s >= 6 && iow));
      tq  = (n >= 1088 && n < 1632);
      chk_run(n, pe, de, tq);
      case (n)
        238:  poc_pad  = 1'b0;  // mid M1 of first cycle
        826:  test_pad = 1'b1;  // M2 of second cycle
        960:  io_write = 1'b0;  // after X1->X2 latch
        1100: test_pad = 1'b0;
        1500: io_write = 1'b1;  // after X1->X2 latch with io_write low
        1732: poc_pad  = 1'b1;
        default: ;
      endcase
    end
    // n = 2550 is mid X1 with clk2 high: reset must act without a clock edge
    #3 poc_n = 1'b0;
    #1 chk_reset("async");
    @(negedge sysclk);
    @(negedge sysclk);
    chk_reset("hold");
    poc_n = 1'b1;
`ifdef SUBCYCLE_SEQUENCER_SINGLE_STEP_EN
    halt = 1'b1;
    for (int m = 0; m < 1121; m++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      if (m < 544) chk_run(m, 1'b1, 1'b0, 1'b0);
      else if (m < 563) chk_frozen();
      else if (m < 1107) chk_run(m - 563, 1'b1, 1'b0, 1'b0);
      else chk_frozen();
      if (m == 560) step = 1'b1;
      if (m == 570) step = 1'b0;
    end
`else
    for (int m = 0; m < 140; m++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      chk_run(m, 1'b1, 1'b0, 1'b0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/subcycle_sequencer.md
Name: subcycle_sequencer

Overview:
- Master timing controller for the i4004 core.
- Divides sysclk into the two-phase clk1/clk2 pair.
- Steps the 8-subcycle instruction cycle (A1, A2, A3, M1, M2, X1, X2, X3) and emits one-hot subcycle strobes, sync, power-on-clear and data-bus direction control.
- Sits in front of the timing/I/O interface; its outputs are the only source of subcycle timing for the CPU datapath.

Parameters:
- PHI1_W, 20, sysclk cycles clk1 is high.
- GAP12_W, 10, sysclk cycles from clk1 falling to clk2 rising.
- PHI2_W, 20, sysclk cycles clk2 is high.
- GAP21_W, 18, sysclk cycles from clk2 falling to next clk1 rising. Default phase total is 68 sysclk = 1360 ns at 20 ns sysclk.

Ports:
- sysclk  in  1  system clock; all state on rising edge.
- poc_n  in  1  asynchronous active-low reset.
- poc_pad  in  1  external power-on-clear request, active high, asynchronous.
- test_pad  in  1  external TEST pin, asynchronous.
- io_write  in  1  CPU drives bus during X2/X3 of this cycle.
- clk1, clk2  out  1  two-phase non-overlapping clocks.
- a12, a22, a32, m12, m22, x12, x22, x32  out  1 each  one-hot subcycle strobes.
- sync  out  1  high for the whole X3 subcycle.
- poc  out  1  internal power-on-clear.
- data_oe  out  1  CPU drives data bus.
- test_q  out  1  TEST sampled at the end of X3.
- subcycle  out  3  encoded subcycle, 0 = A1 … 7 = X3.

Behaviour:
- Reset (poc_n low, async):
  - phase counter = 0; sequencer in IDLE.
  - clk1 = clk2 = 0; all strobes = 0; sync = 0.
  - poc = 1; data_oe = 0; test_q = 0; subcycle = 7.
- Phase counter:
  - cnt counts 0..T-1, where T = PHI1_W+GAP12_W+PHI2_W+GAP21_W, and wraps to 0.
  - clk1 = (cnt < PHI1_W).
  - clk2 = (PHI1_W+GAP12_W <= cnt < PHI1_W+GAP12_W+PHI2_W).
  - Both are registered, glitch-free and never high simultaneously.
- Start-up:
  - First rising sysclk edge after poc_n deasserts leaves IDLE.
  - On that edge: cnt = 0, subcycle = 0 (A1), a12 = 1, clk1 = 1.
- Subcycle advance:
  - On the edge where cnt wraps T-1 -> 0, subcycle increments mod 8 (X3 -> A1).
  - Exactly one strobe is high at all times outside IDLE.
  - Strobes, sync and subcycle change on the same edge as clk1 rising.
- sync = (subcycle == 7).
- POC synchronizer:
  - poc_pad passes through a 2-flop synchronizer.
  - Synchronized high drives poc = 1 within 3 sysclk edges, at any point.
  - poc falls only on an X3->A1 advance edge with synchronized poc_pad low, so release is cycle-aligned.
  - poc_pad pulses shorter than 2 sysclk may be missed.
- data_oe:
  - Asserted in A1, A2, A3 (address out).
  - Asserted in X2, X3 if io_write was high at the X1->X2 advance edge (latched once per cycle).
  - Deasserted in M1, M2, X1.
  - Forced 0 whenever poc = 1.
- TEST:
  - test_pad is 2-flop synchronized.
  - test_q loads the synchronized value on the X3->A1 edge and holds for the whole next cycle.
- poc does not stop the sequencer; clocks and strobes keep running during clear.
- Reset mid-cycle: everything returns to the reset values immediately; restart always begins at A1.
- Parameter widths: cnt width = clog2(T). Any parameter < 1 is a configuration error; flag it with an initial-block $error.

Optional Feature:
- Macro SUBCYCLE_SEQUENCER_SINGLE_STEP_EN adds inputs halt and step.
- Halt behaviour:
  - If halt is high at an X3->A1 wrap, the sequencer holds cnt = T-1 in X3, with clk1 = clk2 = 0.
  - A rising edge on step (synchronized) releases exactly one full 8-subcycle cycle, then re-checks halt.
  - Deasserting halt resumes free-running at the next edge.
  - poc rising while halted forces immediate resume.
- Without the macro: ports absent, sequencer always free-runs.

Test Plan:
- Release poc_n at t=100 ns -> next edge a12=1, clk1=1. clk1 high 20 sysclk, low 10, then clk2 high 20, then 18 low. a22 rises at sysclk 68 after start.
- Run 3 full cycles -> strobe order A1..X3 repeats. Each strobe lasts 68 sysclk, one-hot holds every edge, sync high exactly 68 sysclk per 544, clk1 & clk2 never both 1.
- Hold poc_pad=1 from reset, drop it mid-M1 -> poc stays 1 until the next X3->A1 edge, then 0. data_oe stays 0 while poc=1.
- io_write=1 at the X1->X2 edge -> data_oe=1 through X2, X3. With io_write=0 -> data_oe=0 in X2/X3. data_oe=1 in A1..A3 in both cases.
- test_pad toggles 1 during M2 -> test_q=1 from the following A1 edge for one full cycle.
- Assert poc_n low mid-X1 -> all outputs take reset values asynchronously; after release, sequence restarts at A1.
- (SINGLE_STEP_EN) halt=1 -> frozen in X3. One step pulse -> exactly 544 sysclk of activity, then frozen in X3 again.
